// File: rtl/rv_fetch_ctrl.sv
// Instruction fetch controller: issues one word fetch at a time, pushes the returned
// halfwords into the fetch buffer and handles redirects (flush) and buffer back-pressure.
module rv_fetch_ctrl #(
    parameter int unsigned                     IADDR_SPACE_BITS = 16,
    parameter logic [IADDR_SPACE_BITS-1:0]     RESET_ADDR       = '0
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_flush,
    input  logic [IADDR_SPACE_BITS-1:1]     i_pc_target,
    input  logic                            i_buf_full,
    output logic                            o_instr_req,
    output logic [IADDR_SPACE_BITS-1:2]     o_instr_addr,
    input  logic                            i_instr_ack,
    input  logic                            i_instr_rvalid,
    input  logic [31:0]                     i_instr_rdata,
    output logic [15:0]                     o_data_lo,
    output logic [15:0]                     o_data_hi,
    output logic                            o_push_single,
    output logic                            o_push_double,
    output logic                            o_buf_reset_n,
    output logic [IADDR_SPACE_BITS-1:1]     o_pc
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_REQ,
        ST_WAIT,
        ST_IDLE,
        ST_DISCARD
    } state_t;

    localparam logic [IADDR_SPACE_BITS-3:0] WORD_ONE = 1;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [IADDR_SPACE_BITS-1:1]     r_fetch_pc;
    logic [IADDR_SPACE_BITS-1:1]     w_fetch_pc_nxt;
    logic [IADDR_SPACE_BITS-1:2]     w_word_inc;
    logic                            w_push;
    logic                            w_resume_state_req;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_RESET;
            r_fetch_pc <= RESET_ADDR[IADDR_SPACE_BITS-1:1];
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    assign w_word_inc         = r_fetch_pc[IADDR_SPACE_BITS-1:2] + WORD_ONE;
    assign w_resume_state_req = !i_buf_full;

    // Next-state and fetch address; flush overrides any push in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;

        if (i_flush) begin
            w_fetch_pc_nxt = i_pc_target;
            unique case (r_state)
                ST_RESET, ST_IDLE: begin
                    w_state_nxt = w_resume_state_req ? ST_REQ : ST_IDLE;
                end
                ST_REQ: begin
                    if (i_instr_ack) begin
                        w_state_nxt = ST_DISCARD;
                    end else begin
                        w_state_nxt = w_resume_state_req ? ST_REQ : ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    w_state_nxt = i_instr_rvalid ? ST_REQ : ST_DISCARD;
                end
                ST_DISCARD: begin
                    w_state_nxt = i_instr_rvalid ? ST_REQ : ST_DISCARD;
                end
                default: begin
                    w_state_nxt = ST_RESET;
                end
            endcase
        end else begin
            unique case (r_state)
                ST_RESET: begin
                    w_state_nxt = w_resume_state_req ? ST_REQ : ST_IDLE;
                end
                ST_REQ: begin
                    if (i_instr_ack) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_instr_rvalid) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = {w_word_inc, 1'b0};
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_resume_state_req) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (i_instr_rvalid) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_RESET;
                end
            endcase
        end
    end

    // Outputs are gated by i_reset_n because the state register only resets on the edge.
    always_comb begin
        o_instr_req   = 1'b0;
        o_push_single = 1'b0;
        o_push_double = 1'b0;
        o_data_lo     = '0;
        o_data_hi     = '0;
        o_instr_addr  = r_fetch_pc[IADDR_SPACE_BITS-1:2];
        o_buf_reset_n = i_reset_n & !i_flush & (r_state != ST_RESET);
        o_pc          = i_pc_target;

        if (!i_reset_n || r_state == ST_RESET) begin
            o_pc = RESET_ADDR[IADDR_SPACE_BITS-1:1];
        end

        if (i_reset_n) begin
            o_instr_req = (r_state == ST_REQ);
            if (w_push) begin
                o_data_hi = i_instr_rdata[31:16];
                if (r_fetch_pc[1]) begin
                    o_push_single = 1'b1;
                end else begin
                    o_push_double = 1'b1;
                    o_data_lo     = i_instr_rdata[15:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Directed bench for rv_fetch_ctrl with hand-computed expectations (RESET_ADDR = 0x0100).
module tb_rv_fetch_ctrl;

    localparam int unsigned W = 16;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic [W-1:1]  pc_target;
    logic          buf_full;
    logic          instr_req;
    logic [W-1:2]  instr_addr;
    logic          instr_ack;
    logic          instr_rvalid;
    logic [31:0]   instr_rdata;
    logic [15:0]   data_lo;
    logic [15:0]   data_hi;
    logic          push_single;
    logic          push_double;
    logic          buf_reset_n;
    logic [W-1:1]  pc_out;

    int n_checks = 0;
    int n_errors = 0;

    rv_fetch_ctrl #(
        .IADDR_SPACE_BITS (W),
        .RESET_ADDR       (16'h0100)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_flush        (flush),
        .i_pc_target    (pc_target),
        .i_buf_full     (buf_full),
        .o_instr_req    (instr_req),
        .o_instr_addr   (instr_addr),
        .i_instr_ack    (instr_ack),
        .i_instr_rvalid (instr_rvalid),
        .i_instr_rdata  (instr_rdata),
        .o_data_lo      (data_lo),
        .o_data_hi      (data_hi),
        .o_push_single  (push_single),
        .o_push_double  (push_double),
        .o_buf_reset_n  (buf_reset_n),
        .o_pc           (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        pc_target    = '0;
        buf_full     = 1'b0;
        instr_ack    = 1'b0;
        instr_rvalid = 1'b0;
        instr_rdata  = '0;
        step();
        step();

        // Reset values
        settle();
        check("rst_req",    32'(instr_req),   32'h0);
        check("rst_single", 32'(push_single), 32'h0);
        check("rst_double", 32'(push_double), 32'h0);
        check("rst_lo",     32'(data_lo),     32'h0);
        check("rst_hi",     32'(data_hi),     32'h0);
        check("rst_bufrst", 32'(buf_reset_n), 32'h0);
        check("rst_pc",     32'(pc_out),      32'h080);

        // First fetch after release
        reset_n = 1'b1;
        settle();
        check("rstst_bufrst", 32'(buf_reset_n), 32'h0);
        check("rstst_pc",     32'(pc_out),      32'h080);
        check("rstst_req",    32'(instr_req),   32'h0);
        step();
        check("req0_req",  32'(instr_req),  32'h1);
        check("req0_addr", 32'(instr_addr), 32'h040);
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        settle();
        check("wait_req",    32'(instr_req),   32'h0);
        check("wait_double", 32'(push_double), 32'h0);
        step();
        instr_rvalid = 1'b1;
        instr_rdata  = 32'h0013_0013;
        settle();
        check("p0_double", 32'(push_double), 32'h1);
        check("p0_single", 32'(push_single), 32'h0);
        check("p0_lo",     32'(data_lo),     32'h0013);
        check("p0_hi",     32'(data_hi),     32'h0013);
        step();
        instr_rvalid = 1'b0;
        settle();
        check("idle_req",    32'(instr_req),   32'h0);
        check("idle_double", 32'(push_double), 32'h0);
        step();
        check("req1_req",  32'(instr_req),  32'h1);
        check("req1_addr", 32'(instr_addr), 32'h041);

        // Flush to odd halfword, single push
        flush     = 1'b1;
        pc_target = 15'h0103;
        settle();
        check("fl_bufrst", 32'(buf_reset_n), 32'h0);
        check("fl_pc",     32'(pc_out),      32'h103);
        step();
        flush = 1'b0;
        settle();
        check("req2_addr",   32'(instr_addr),  32'h081);
        check("req2_bufrst", 32'(buf_reset_n), 32'h1);
        instr_ack = 1'b1;
        step();
        instr_ack    = 1'b0;
        instr_rvalid = 1'b1;
        instr_rdata  = 32'hABCD_1234;
        settle();
        check("p1_single", 32'(push_single), 32'h1);
        check("p1_double", 32'(push_double), 32'h0);
        check("p1_hi",     32'(data_hi),     32'hABCD);
        step();
        instr_rvalid = 1'b0;
        step();
        check("req3_addr", 32'(instr_addr), 32'h082);

        // Flush while waiting, late rvalid is discarded
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        flush     = 1'b1;
        pc_target = 15'h0200;
        step();
        flush = 1'b0;
        settle();
        check("disc_req", 32'(instr_req), 32'h0);
        step();
        instr_rvalid = 1'b1;
        instr_rdata  = 32'h5555_AAAA;
        settle();
        check("disc_single", 32'(push_single), 32'h0);
        check("disc_double", 32'(push_double), 32'h0);
        step();
        instr_rvalid = 1'b0;
        settle();
        check("req4_req",  32'(instr_req),  32'h1);
        check("req4_addr", 32'(instr_addr), 32'h100);

        // Flush coinciding with rvalid in WAIT: data dropped, straight to REQ
        instr_ack = 1'b1;
        step();
        instr_ack    = 1'b0;
        instr_rvalid = 1'b1;
        flush        = 1'b1;
        pc_target    = 15'h7FFE;
        settle();
        check("flrv_double", 32'(push_double), 32'h0);
        check("flrv_single", 32'(push_single), 32'h0);
        step();
        instr_rvalid = 1'b0;
        flush        = 1'b0;
        settle();
        check("req5_req",  32'(instr_req),  32'h1);
        check("req5_addr", 32'(instr_addr), 32'h3FFF);

        // Address wrap after a double push at the top word
        instr_ack = 1'b1;
        step();
        instr_ack    = 1'b0;
        instr_rvalid = 1'b1;
        instr_rdata  = 32'h1111_2222;
        settle();
        check("p2_double", 32'(push_double), 32'h1);
        check("p2_lo",     32'(data_lo),     32'h2222);
        check("p2_hi",     32'(data_hi),     32'h1111);
        step();
        instr_rvalid = 1'b0;
        step();
        check("wrap_addr", 32'(instr_addr), 32'h0000);

        // Back-pressure in IDLE; stray rvalid there is ignored
        instr_ack = 1'b1;
        step();
        instr_ack    = 1'b0;
        instr_rvalid = 1'b1;
        instr_rdata  = 32'h0000_0001;
        buf_full     = 1'b1;
        step();
        instr_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr_rvalid = (i == 2);
            settle();
            check("full_req",    32'(instr_req),   32'h0);
            check("full_double", 32'(push_double), 32'h0);
            step();
        end
        instr_rvalid = 1'b0;
        buf_full     = 1'b0;
        settle();
        check("unfull_req0", 32'(instr_req), 32'h0);
        step();
        check("unfull_req1",  32'(instr_req),  32'h1);
        check("unfull_addr",  32'(instr_addr), 32'h0001);

        // Reset in WAIT, rvalid arriving in RESET is dropped
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        reset_n   = 1'b0;
        settle();
        check("mrst_req",    32'(instr_req),   32'h0);
        check("mrst_bufrst", 32'(buf_reset_n), 32'h0);
        check("mrst_pc",     32'(pc_out),      32'h080);
        step();
        reset_n      = 1'b1;
        instr_rvalid = 1'b1;
        instr_rdata  = 32'hDEAD_BEEF;
        settle();
        check("mrst_single", 32'(push_single), 32'h0);
        check("mrst_double", 32'(push_double), 32'h0);
        check("mrst_rstst",  32'(buf_reset_n), 32'h0);
        step();
        instr_rvalid = 1'b0;
        settle();
        check("req6_req",  32'(instr_req),  32'h1);
        check("req6_addr", 32'(instr_addr), 32'h040);

        // Flush in IDLE with buffer full stays idle
        instr_ack = 1'b1;
        step();
        instr_ack    = 1'b0;
        instr_rvalid = 1'b1;
        buf_full     = 1'b1;
        step();
        instr_rvalid = 1'b0;
        flush        = 1'b1;
        pc_target    = 15'h0300;
        step();
        flush = 1'b0;
        settle();
        check("flidle_req", 32'(instr_req), 32'h0);
        buf_full = 1'b0;
        step();
        check("req7_req",  32'(instr_req),  32'h1);
        check("req7_addr", 32'(instr_addr), 32'h180);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
